// File: rtl/median_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : median_avg_pkg
// Description : Shared types and helpers for the median/average filter.
//               Holds the controller state encoding, the median rank helper
//               and the parameter legality check used at elaboration.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package median_avg_pkg;

    // Controller states: wait for a full window, rank candidates, publish.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RANK = 2'd1,
        ACC  = 2'd2
    } state_t;

    // Rank of the median inside an odd-length window (0-based).
    function automatic int med_k(input int med_n);
        return (med_n - 1) / 2;
    endfunction

    // Legal configuration: odd window of 3..15 samples, 2..64 medians/average.
    function automatic bit med_params_ok(input int med_n, input int avg_log2);
        return (med_n >= 3) && (med_n <= 15) && ((med_n % 2) == 1) &&
               (avg_log2 >= 1) && (avg_log2 <= 6);
    endfunction

endpackage
`default_nettype wire

// File: rtl/median_rank_unit.sv
`default_nettype none
// ============================================================================
// Module      : median_rank_unit
// Description : Combinational rank counters. Compares one candidate against
//               every window entry and reports how many entries are strictly
//               smaller (lt_o) and how many are smaller or equal (le_o).
// Ports       : cand_i  - candidate sample
//               win_i   - full window, MED_N entries of DATA_W bits
//               lt_o    - count(win_i[j] <  cand_i)
//               le_o    - count(win_i[j] <= cand_i)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module median_rank_unit #(
    parameter  int DATA_W = 16,
    parameter  int MED_N  = 5,
    localparam int CNT_W  = $clog2(MED_N + 1)
) (
    input  logic [DATA_W-1:0]            cand_i,
    input  logic [MED_N-1:0][DATA_W-1:0] win_i,
    output logic [CNT_W-1:0]             lt_o,
    output logic [CNT_W-1:0]             le_o
);

    always_comb begin
        lt_o = '0;
        le_o = '0;
        for (int j = 0; j < MED_N; j++) begin
            if (win_i[j] < cand_i) begin
                lt_o = lt_o + 1'b1;
            end
            if (win_i[j] <= cand_i) begin
                le_o = le_o + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/median_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : median_avg_filter
// Description : Sliding-window median of MED_N strobed samples followed by an
//               average over 2**AVG_LOG2 medians (block or running mode).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               data_i        - unsigned sample, valid with data_av_i
//               data_av_i     - one-cycle sample strobe
//               median_o      - last median, median_en_o pulses on update
//               avg_o         - last average, avg_o_en pulses on update
//               busy_o        - a median is in flight; strobes are dropped
//               overrun_o     - sticky, a strobe was dropped
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module median_avg_filter
    import median_avg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MED_N    = 5,
    parameter int AVG_LOG2 = 3,
    parameter int AVG_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_av_i,
    output logic [DATA_W-1:0] median_o,
    output logic              median_en_o,
    output logic [DATA_W-1:0] avg_o,
    output logic              avg_o_en,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int CNT_W = $clog2(MED_N + 1);
    localparam int IDX_W = $clog2(MED_N);
    localparam int ACC_W = DATA_W + AVG_LOG2;

    localparam logic [CNT_W-1:0] C_FILL_FULL = CNT_W'(MED_N);
    localparam logic [CNT_W-1:0] C_FILL_LAST = CNT_W'(MED_N - 1);
    localparam logic [CNT_W-1:0] C_K         = CNT_W'(med_k(MED_N));
    localparam logic [IDX_W-1:0] C_K_LAST    = IDX_W'(MED_N - 1);

    if (!med_params_ok(MED_N, AVG_LOG2)) begin : g_param_check
        $error("median_avg_filter: MED_N must be odd in 3..15 and AVG_LOG2 in 1..6");
    end

    state_t                       state_q, state_d;
    logic [MED_N-1:0][DATA_W-1:0] window_q;
    logic [CNT_W-1:0]             fill_q;
    logic [IDX_W-1:0]             k_q;
    logic                         found_q;
    logic [DATA_W-1:0]            cand_q;
    logic [DATA_W-1:0]            median_q;
    logic                         median_en_q;
    logic [DATA_W-1:0]            avg_q;
    logic                         avg_en_q;
    logic [DATA_W-1:0]            avg_pend_q;
    logic                         avg_pend_v_q;
    logic                         overrun_q;

    logic                         w_busy;
    logic                         w_accept;
    logic                         w_is_acc;
    logic                         w_qual;
    logic [DATA_W-1:0]            w_cand;
    logic [CNT_W-1:0]             w_lt;
    logic [CNT_W-1:0]             w_le;
    logic                         w_avg_fire;
    logic [DATA_W-1:0]            w_avg_val;

    // The publish cycle still counts as busy so a strobe landing on
    // median_en_o is rejected rather than restarting the ranker.
    assign w_busy   = (state_q != IDLE) || median_en_q;
    assign w_accept = data_av_i && !w_busy;
    assign w_is_acc = (state_q == ACC);
    assign w_cand   = window_q[k_q];

    median_rank_unit #(
        .DATA_W (DATA_W),
        .MED_N  (MED_N)
    ) u_rank (
        .cand_i (w_cand),
        .win_i  (window_q),
        .lt_o   (w_lt),
        .le_o   (w_le)
    );

    // Candidate is the median when exactly K entries can sit below it;
    // with duplicates several candidates qualify and the first one wins.
    assign w_qual = (w_lt <= C_K) && (C_K < w_le);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // fill_q is pre-shift: MED_N-1 means this strobe completes it
                if (w_accept && (fill_q >= C_FILL_LAST)) begin
                    state_d = RANK;
                end
            end
            RANK: begin
                if (k_q == C_K_LAST) begin
                    state_d = ACC;
                end
            end
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Window, ranking and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q     <= '0;
            fill_q       <= '0;
            k_q          <= '0;
            found_q      <= 1'b0;
            cand_q       <= '0;
            median_q     <= '0;
            median_en_q  <= 1'b0;
            avg_q        <= '0;
            avg_en_q     <= 1'b0;
            avg_pend_q   <= '0;
            avg_pend_v_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (w_accept) begin
                window_q <= {window_q[MED_N-2:0], data_i};
                if (fill_q != C_FILL_FULL) begin
                    fill_q <= fill_q + 1'b1;
                end
            end

            if (data_av_i && w_busy) begin
                overrun_q <= 1'b1;
            end

            median_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    k_q     <= '0;
                    found_q <= 1'b0;
                end
                RANK: begin
                    if (k_q != C_K_LAST) begin
                        k_q <= k_q + 1'b1;
                    end
                    if (!found_q && w_qual) begin
                        found_q <= 1'b1;
                        cand_q  <= w_cand;
                    end
                end
                ACC: begin
                    median_q    <= cand_q;
                    median_en_q <= 1'b1;
                end
                default: ;
            endcase

            // Average is staged one cycle so avg_o_en trails median_en_o.
            avg_pend_v_q <= w_avg_fire;
            if (w_avg_fire) begin
                avg_pend_q <= w_avg_val;
            end
            avg_en_q <= avg_pend_v_q;
            if (avg_pend_v_q) begin
                avg_q <= avg_pend_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Averager
    // ------------------------------------------------------------------
    if (AVG_MODE == 0) begin : g_block
        localparam logic [AVG_LOG2-1:0] C_MCNT_LAST = AVG_LOG2'(AVG_N - 1);

        logic [ACC_W-1:0]    acc_q;
        logic [AVG_LOG2-1:0] mcnt_q;
        logic [ACC_W-1:0]    w_acc_sum;

        // Sum including the median being published this cycle.
        assign w_acc_sum  = acc_q + ACC_W'(cand_q);
        assign w_avg_fire = w_is_acc && (mcnt_q == C_MCNT_LAST);
        assign w_avg_val  = DATA_W'(w_acc_sum >> AVG_LOG2);

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q  <= '0;
                mcnt_q <= '0;
            end else if (w_is_acc) begin
                mcnt_q <= mcnt_q + 1'b1;
                acc_q  <= (mcnt_q == C_MCNT_LAST) ? '0 : w_acc_sum;
            end
        end
    end else begin : g_running
        localparam int SEEN_W = AVG_LOG2 + 1;
        localparam logic [SEEN_W-1:0] C_SEEN_FULL = SEEN_W'(AVG_N);
        localparam logic [SEEN_W-1:0] C_SEEN_LAST = SEEN_W'(AVG_N - 1);

        logic [AVG_N-1:0][DATA_W-1:0] ring_q;
        logic [AVG_LOG2-1:0]          wr_q;
        logic [SEEN_W-1:0]            seen_q;
        logic [ACC_W-1:0]             sum_q;
        logic [ACC_W-1:0]             w_sum_new;

        // ring_q[wr_q] is the oldest median; it is always part of sum_q
        // (zero before the ring fills), so the subtraction cannot wrap.
        assign w_sum_new  = sum_q + ACC_W'(cand_q) - ACC_W'(ring_q[wr_q]);
        assign w_avg_fire = w_is_acc && (seen_q >= C_SEEN_LAST);
        assign w_avg_val  = DATA_W'(w_sum_new >> AVG_LOG2);

        always_ff @(posedge clk) begin
            if (rst) begin
                ring_q <= '0;
                wr_q   <= '0;
                seen_q <= '0;
                sum_q  <= '0;
            end else if (w_is_acc) begin
                ring_q[wr_q] <= cand_q;
                wr_q         <= wr_q + 1'b1;
                sum_q        <= w_sum_new;
                if (seen_q != C_SEEN_FULL) begin
                    seen_q <= seen_q + 1'b1;
                end
            end
        end
    end

    assign median_o    = median_q;
    assign median_en_o = median_en_q;
    assign avg_o       = avg_q;
    assign avg_o_en    = avg_en_q;
    assign busy_o      = w_busy;
    assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_median_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_avg_filter
// Description : Directed self-checking bench. Three filter instances:
//               0 = block mode  MED_N=3 AVG_LOG2=2
//               1 = running mode MED_N=3 AVG_LOG2=2
//               2 = default parameters (MED_N=5 AVG_LOG2=3 block)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_avg_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [3];
    logic        av     [3];
    logic [15:0] din    [3];
    logic [15:0] med_w  [3];
    logic [15:0] avg_w  [3];
    logic        men    [3];
    logic        aen    [3];
    logic        busy   [3];
    logic        ovr    [3];

    int checks   = 0;
    int failures = 0;
    int medn [3] = '{3, 3, 5};

    int r_men_cnt, r_men_cyc, r_med_val;
    int r_aen_cnt, r_aen_cyc, r_avg_val;
    int r_busy_drop, r_post_med, r_post_avg, r_post_flags;

    int a_v [6] = '{150, 100, 10, 40, 250, 110};
    int a_m [6] = '{-1, -1, 100, 40, 40, 110};
    int a_a [6] = '{-1, -1, -1, -1, -1, 72};
    int b_v [7] = '{150, 100, 10, 40, 250, 110, 35};
    int b_m [7] = '{-1, -1, 100, 40, 40, 110, 110};
    int b_a [7] = '{-1, -1, -1, -1, -1, 72, 75};
    int c_v [12] = '{7, 7, 3, 7, 9, 20, 1, 50, 30, 100, 60, 5};
    int c_m [12] = '{-1, -1, -1, -1, 7, 7, 7, 9, 20, 30, 50, 50};
    int c_a [12] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 22};

    median_avg_filter #(.DATA_W(16), .MED_N(3), .AVG_LOG2(2), .AVG_MODE(0)) u_blk (
        .clk(clk), .rst(rst_v[0]), .data_i(din[0]), .data_av_i(av[0]),
        .median_o(med_w[0]), .median_en_o(men[0]), .avg_o(avg_w[0]),
        .avg_o_en(aen[0]), .busy_o(busy[0]), .overrun_o(ovr[0]));

    median_avg_filter #(.DATA_W(16), .MED_N(3), .AVG_LOG2(2), .AVG_MODE(1)) u_run (
        .clk(clk), .rst(rst_v[1]), .data_i(din[1]), .data_av_i(av[1]),
        .median_o(med_w[1]), .median_en_o(men[1]), .avg_o(avg_w[1]),
        .avg_o_en(aen[1]), .busy_o(busy[1]), .overrun_o(ovr[1]));

    median_avg_filter u_def (
        .clk(clk), .rst(rst_v[2]), .data_i(din[2]), .data_av_i(av[2]),
        .median_o(med_w[2]), .median_en_o(men[2]), .avg_o(avg_w[2]),
        .avg_o_en(aen[2]), .busy_o(busy[2]), .overrun_o(ovr[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one strobe to instance u, then watch 12 cycles. Cycle c is the
    // cycle after edge E0+c, E0 being the edge that samples the strobe.
    // drop_at: present a second strobe (value 999) during that cycle.
    // rst_at : hold rst during that cycle; outputs recorded one cycle later.
    task automatic send(input int u, input int v, input int drop_at, input int rst_at);
        r_men_cnt = 0; r_men_cyc = -1; r_med_val = -1;
        r_aen_cnt = 0; r_aen_cyc = -1; r_avg_val = -1;
        r_busy_drop = -1; r_post_med = -1; r_post_avg = -1; r_post_flags = -1;
        @(negedge clk);
        din[u] = 16'(v);
        av[u]  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (men[u]) begin
                r_men_cnt++;
                r_men_cyc = c;
                r_med_val = int'(med_w[u]);
            end
            if (aen[u]) begin
                r_aen_cnt++;
                r_aen_cyc = c;
                r_avg_val = int'(avg_w[u]);
            end
            av[u] = 1'b0;
            if (c == drop_at) begin
                r_busy_drop = int'(busy[u]);
                din[u] = 16'd999;
                av[u]  = 1'b1;
            end
            if (c == rst_at) begin
                rst_v[u] = 1'b1;
            end
            if (c == rst_at + 1) begin
                r_post_med   = int'(med_w[u]);
                r_post_avg   = int'(avg_w[u]);
                r_post_flags = int'({men[u], aen[u], busy[u], ovr[u]});
                rst_v[u] = 1'b0;
            end
        end
    endtask

    task automatic expect_res(input string tag, input int u, input int em, input int ea);
        chk({tag, ".men_cnt"}, r_men_cnt, (em >= 0) ? 1 : 0);
        if (em >= 0) begin
            chk({tag, ".men_cyc"}, r_men_cyc, medn[u] + 1);
            chk({tag, ".median_o"}, r_med_val, em);
        end
        chk({tag, ".aen_cnt"}, r_aen_cnt, (ea >= 0) ? 1 : 0);
        if (ea >= 0) begin
            chk({tag, ".aen_cyc"}, r_aen_cyc, medn[u] + 2);
            chk({tag, ".avg_o"}, r_avg_val, ea);
        end
    endtask

    initial begin
        int dup_cnt;

        for (int u = 0; u < 3; u++) begin
            rst_v[u] = 1'b1;
            av[u]    = 1'b0;
            din[u]   = 16'd0;
        end
        repeat (3) @(negedge clk);

        // Reset values on every instance
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst%0d.median_o", u),    int'(med_w[u]), 0);
            chk($sformatf("rst%0d.median_en_o", u), int'(men[u]),   0);
            chk($sformatf("rst%0d.avg_o", u),       int'(avg_w[u]), 0);
            chk($sformatf("rst%0d.avg_o_en", u),    int'(aen[u]),   0);
            chk($sformatf("rst%0d.busy_o", u),      int'(busy[u]),  0);
            chk($sformatf("rst%0d.overrun_o", u),   int'(ovr[u]),   0);
            rst_v[u] = 1'b0;
        end

        // Block mode stream
        for (int i = 0; i < 6; i++) begin
            send(0, a_v[i], -1, -1);
            expect_res($sformatf("blk%0d", i), 0, a_m[i], a_a[i]);
        end
        chk("blk.avg_hold", int'(avg_w[0]), 72);
        chk("blk.ovr_clear", int'(ovr[0]), 0);

        // Overrun: second strobe two edges after the accepted one
        send(0, 300, 1, -1);
        expect_res("ovr0", 0, 250, -1);
        chk("ovr.busy_at_drop", r_busy_drop, 1);
        chk("ovr.overrun_o", int'(ovr[0]), 1);
        send(0, 5, -1, -1);
        expect_res("ovr1", 0, 110, -1);
        chk("ovr.sticky", int'(ovr[0]), 1);

        // Running mode stream
        for (int i = 0; i < 7; i++) begin
            send(1, b_v[i], -1, -1);
            expect_res($sformatf("run%0d", i), 1, b_m[i], b_a[i]);
        end
        chk("run.avg_hold", int'(avg_w[1]), 75);

        // Reset in the middle of ranking
        send(1, 77, -1, 1);
        expect_res("rstmid", 1, -1, -1);
        chk("rstmid.median_o", r_post_med, 0);
        chk("rstmid.avg_o", r_post_avg, 0);
        chk("rstmid.flags", r_post_flags, 0);
        send(1, 1, -1, -1);
        expect_res("rstmid.s1", 1, -1, -1);
        send(1, 2, -1, -1);
        expect_res("rstmid.s2", 1, -1, -1);
        send(1, 3, -1, -1);
        expect_res("rstmid.s3", 1, 2, -1);

        // Default parameters: duplicates, latency and the 8-median average
        dup_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            send(2, c_v[i], -1, -1);
            expect_res($sformatf("def%0d", i), 2, c_m[i], c_a[i]);
            if (i < 5) dup_cnt += r_men_cnt;
        end
        chk("dup.median_count", dup_cnt, 1);
        chk("def.avg_hold", int'(avg_w[2]), 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
